// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the RV64 multi-cycle controller: opcodes, FSM state
// encodings, ALU source/op select codes and the bundled control word.
package multicycle_ctrl_pkg;

    localparam int CNT_W_DEF    = 64;
    localparam int WAIT_MAX_DEF = 15;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_ALU = 4'd7,
        S_WB_MEM = 4'd8,
        S_BRANCH = 4'd9,
        S_TRAP   = 4'd10
    } state_e;

    typedef enum logic [1:0] {
        SRC_A_PC     = 2'b00,
        SRC_A_RS1    = 2'b01,
        SRC_A_OLD_PC = 2'b10
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'b00,
        SRC_B_FOUR = 2'b01,
        SRC_B_IMM  = 2'b10
    } alu_src_b_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        alu_src_a_e alu_src_a;
        alu_src_b_e alu_src_b;
        alu_op_e    alu_op;
        logic       mem_to_reg;
        logic       pc_src;
        logic       trap;
    } ctrl_t;

    // States that hold a request on the shared memory port and may stall on it.
    function automatic logic is_mem_wait_state(state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: decode inputs, memory handshake, every
// datapath enable/select, and the debug state/counter outputs.
interface multicycle_ctrl_if
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             zero;
    logic             mem_ready;

    logic             pc_write;
    logic             ir_write;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             i_or_d;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             mem_to_reg;
    logic             pc_src;

    logic [3:0]       state;
    logic             trap;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, funct3, zero, mem_ready,
        output pc_write, ir_write, reg_write, mem_read, mem_write, i_or_d,
               alu_src_a, alu_src_b, alu_op, mem_to_reg, pc_src,
               state, trap, cycle_count, instr_count
    );

    modport slave (
        output opcode, funct3, zero, mem_ready,
        input  pc_write, ir_write, reg_write, mem_read, mem_write, i_or_d,
               alu_src_a, alu_src_b, alu_op, mem_to_reg, pc_src,
               state, trap, cycle_count, instr_count
    );

endinterface

// File: rtl/multicycle_ctrl_perf_counters.sv
// Free-running cycle counter and retired-instruction counter; both wrap
// modulo 2^CNT_W and clear on synchronous reset.
module multicycle_ctrl_perf_counters
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_retire,
    input  logic             i_trap,
    output logic [CNT_W-1:0] o_cycle_count,
    output logic [CNT_W-1:0] o_instr_count
);

    logic [CNT_W-1:0] r_cycle_count;
    logic [CNT_W-1:0] r_instr_count;

    // NOTE: state registers use <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cycle_count <= '0;
            r_instr_count <= '0;
        end else begin
            r_cycle_count <= r_cycle_count + 1'b1;
            if (i_retire && !i_trap) begin
                r_instr_count <= r_instr_count + 1'b1;
            end
        end
    end

    assign o_cycle_count = r_cycle_count;
    assign o_instr_count = r_instr_count;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV64 sequencer: FETCH/DECODE/EXECUTE/MEM/WB FSM driving the
// datapath controls, with a memory-stall watchdog that aborts to TRAP.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);

    localparam int                WAIT_W    = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    state_e            r_state;
    state_e            w_next_state;
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait_next;
    logic              w_wait_limit;
    logic              w_retire;
    ctrl_t             w_ctrl;
    ctrl_t             w_ctrl_out;
    logic              w_unused;

    // Trips on the WAIT_MAX-th consecutive stall; a ready in that cycle still wins.
    assign w_wait_limit = !bus.mem_ready && (r_wait == WAIT_LAST);

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin : next_state_logic
        w_next_state = r_state;
        case (r_state)
            S_FETCH: begin
                if (bus.mem_ready)     w_next_state = S_DECODE;
                else if (w_wait_limit) w_next_state = S_TRAP;
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_R_TYPE:         w_next_state = S_EXEC_R;
                    OP_I_TYPE:         w_next_state = S_EXEC_I;
                    OP_LOAD, OP_STORE: w_next_state = S_ADDR;
                    OP_BRANCH:         w_next_state = S_BRANCH;
                    default:           w_next_state = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I: w_next_state = S_WB_ALU;
            S_ADDR: begin
                w_next_state = (bus.opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                if (bus.mem_ready)     w_next_state = S_WB_MEM;
                else if (w_wait_limit) w_next_state = S_TRAP;
            end
            S_MEM_WR: begin
                if (bus.mem_ready)     w_next_state = S_FETCH;
                else if (w_wait_limit) w_next_state = S_TRAP;
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH: w_next_state = S_FETCH;
            S_TRAP:  w_next_state = S_TRAP;
            default: w_next_state = S_TRAP;
        endcase
    end

    always_comb begin : wait_counter_logic
        w_wait_next = '0;
        if (is_mem_wait_state(r_state) && !bus.mem_ready && (w_next_state == r_state)) begin
            w_wait_next = r_wait + 1'b1;
        end
    end

    // Only the last state of an instruction ever transitions back to FETCH.
    assign w_retire = (w_next_state == S_FETCH) && (r_state != S_FETCH);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
        end else begin
            r_state <= w_next_state;
            r_wait  <= w_wait_next;
        end
    end

    always_comb begin : output_decode
        w_ctrl = '0;
        case (r_state)
            S_FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.alu_src_b = SRC_B_FOUR;
                w_ctrl.ir_write  = bus.mem_ready;
                w_ctrl.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                w_ctrl.alu_src_a = SRC_A_OLD_PC;
                w_ctrl.alu_src_b = SRC_B_IMM;
            end
            S_EXEC_R: begin
                w_ctrl.alu_src_a = SRC_A_RS1;
                w_ctrl.alu_src_b = SRC_B_RS2;
                w_ctrl.alu_op    = ALU_FUNCT;
            end
            S_EXEC_I: begin
                w_ctrl.alu_src_a = SRC_A_RS1;
                w_ctrl.alu_src_b = SRC_B_IMM;
                w_ctrl.alu_op    = ALU_FUNCT;
            end
            S_ADDR: begin
                w_ctrl.alu_src_a = SRC_A_RS1;
                w_ctrl.alu_src_b = SRC_B_IMM;
                w_ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WR: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.i_or_d    = 1'b1;
            end
            S_WB_ALU: begin
                w_ctrl.reg_write = 1'b1;
            end
            S_WB_MEM: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a = SRC_A_RS1;
                w_ctrl.alu_src_b = SRC_B_RS2;
                w_ctrl.alu_op    = ALU_SUB;
                w_ctrl.pc_src    = 1'b1;
                w_ctrl.pc_write  = bus.zero ^ bus.funct3[0];
            end
            S_TRAP: begin
                w_ctrl.trap = 1'b1;
            end
            default: w_ctrl = '0;
        endcase
    end

    // While reset is held every request and select is forced low, dropping any access.
    assign w_ctrl_out = reset ? w_ctrl : '0;

    assign bus.pc_write   = w_ctrl_out.pc_write;
    assign bus.ir_write   = w_ctrl_out.ir_write;
    assign bus.reg_write  = w_ctrl_out.reg_write;
    assign bus.mem_read   = w_ctrl_out.mem_read;
    assign bus.mem_write  = w_ctrl_out.mem_write;
    assign bus.i_or_d     = w_ctrl_out.i_or_d;
    assign bus.alu_src_a  = w_ctrl_out.alu_src_a;
    assign bus.alu_src_b  = w_ctrl_out.alu_src_b;
    assign bus.alu_op     = w_ctrl_out.alu_op;
    assign bus.mem_to_reg = w_ctrl_out.mem_to_reg;
    assign bus.pc_src     = w_ctrl_out.pc_src;
    assign bus.trap       = w_ctrl_out.trap;
    assign bus.state      = r_state;

    multicycle_ctrl_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf_counters (
        .clk           (clk),
        .reset         (reset),
        .i_retire      (w_retire),
        .i_trap        (w_ctrl.trap),
        .o_cycle_count (bus.cycle_count),
        .o_instr_count (bus.instr_count)
    );

    // Only funct3[0] distinguishes beq from bne; the upper bits are decoded elsewhere.
    assign w_unused = &{1'b0, bus.funct3[2:1]};

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle control-word and counter
// checks for each instruction class, stalls, traps and mid-access reset.
module tb_multicycle_ctrl;

    localparam int CNT_W = 64;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // {state, pcw irw rw mr mw iod m2r psrc trap, alu_src_a alu_src_b alu_op}
    typedef struct packed {
        logic [3:0] st;
        logic [8:0] en;
        logic [5:0] sel;
    } vec_t;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic       zero;
        logic       rdy;
        logic       ret;
        vec_t       want;
    } step_t;

    localparam vec_t V_RESET     = {4'd0,  9'b000000000, 6'b00_00_00};
    localparam vec_t V_FETCH_RDY = {4'd0,  9'b110100000, 6'b00_01_00};
    localparam vec_t V_FETCH_STL = {4'd0,  9'b000100000, 6'b00_01_00};
    localparam vec_t V_DECODE    = {4'd1,  9'b000000000, 6'b10_10_00};
    localparam vec_t V_EXEC_R    = {4'd2,  9'b000000000, 6'b01_00_10};
    localparam vec_t V_EXEC_I    = {4'd3,  9'b000000000, 6'b01_10_10};
    localparam vec_t V_ADDR      = {4'd4,  9'b000000000, 6'b01_10_00};
    localparam vec_t V_MEM_RD    = {4'd5,  9'b000101000, 6'b00_00_00};
    localparam vec_t V_MEM_WR    = {4'd6,  9'b000011000, 6'b00_00_00};
    localparam vec_t V_WB_ALU    = {4'd7,  9'b001000000, 6'b00_00_00};
    localparam vec_t V_WB_MEM    = {4'd8,  9'b001000100, 6'b00_00_00};
    localparam vec_t V_BR_TAKEN  = {4'd9,  9'b100000010, 6'b01_00_01};
    localparam vec_t V_BR_NOT    = {4'd9,  9'b000000010, 6'b01_00_01};
    localparam vec_t V_TRAP      = {4'd10, 9'b000000001, 6'b00_00_00};

    logic clk = 1'b0;
    logic reset;

    int n_vec = 0;
    int n_err = 0;
    logic [CNT_W-1:0] exp_cyc   = '0;
    logic [CNT_W-1:0] exp_instr = '0;

    multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

    multicycle_ctrl #(
        .CNT_W    (CNT_W),
        .WAIT_MAX (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t observe();
        return {bus.state, bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_read,
                bus.mem_write, bus.i_or_d, bus.mem_to_reg, bus.pc_src, bus.trap,
                bus.alu_src_a, bus.alu_src_b, bus.alu_op};
    endfunction

    function automatic step_t mk(logic [6:0] op, logic [2:0] f3, logic z, logic rdy,
                                 logic ret, vec_t want);
        return {op, f3, z, rdy, ret, want};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) exp_cyc = exp_cyc + 1'b1;
        #1;
    endtask

    task automatic drive(step_t s);
        bus.opcode    = s.op;
        bus.funct3    = s.f3;
        bus.zero      = s.zero;
        bus.mem_ready = s.rdy;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(mk(7'd0, 3'd0, 1'b0, 1'b0, 1'b0, V_RESET));
        tick();
        tick();
        exp_cyc   = '0;
        exp_instr = '0;
        n_vec++;
        if ({observe(), bus.cycle_count, bus.instr_count} !== {V_RESET, exp_cyc, exp_instr}) begin
            n_err++;
            $display("FAIL reset: got %h/%0d/%0d want %h/%0d/%0d", observe(),
                     bus.cycle_count, bus.instr_count, V_RESET, exp_cyc, exp_instr);
        end
        reset = 1'b1;
    endtask

    task automatic test_alu_back_to_back();
        step_t q[$];
        q.push_back(mk(OP_R, 3'd0, 1'b0, 1'b1, 1'b0, V_FETCH_RDY));
        q.push_back(mk(OP_R, 3'd0, 1'b0, 1'b1, 1'b0, V_DECODE));
        q.push_back(mk(OP_R, 3'd0, 1'b0, 1'b1, 1'b0, V_EXEC_R));
        q.push_back(mk(OP_R, 3'd0, 1'b0, 1'b1, 1'b1, V_WB_ALU));
        q.push_back(mk(OP_I, 3'd0, 1'b0, 1'b1, 1'b0, V_FETCH_RDY));
        q.push_back(mk(OP_I, 3'd0, 1'b0, 1'b1, 1'b0, V_DECODE));
        q.push_back(mk(OP_I, 3'd0, 1'b0, 1'b1, 1'b0, V_EXEC_I));
        q.push_back(mk(OP_I, 3'd0, 1'b0, 1'b1, 1'b1, V_WB_ALU));
        foreach (q[i]) begin
            drive(q[i]);
            n_vec++;
            if ({observe(), bus.cycle_count, bus.instr_count} !== {q[i].want, exp_cyc, exp_instr}) begin
                n_err++;
                $display("FAIL alu step %0d: got %h/%0d/%0d want %h/%0d/%0d", i, observe(),
                         bus.cycle_count, bus.instr_count, q[i].want, exp_cyc, exp_instr);
            end
            tick();
            if (q[i].ret) exp_instr++;
        end
    endtask

    task automatic test_mem_ops();
        step_t q[$];
        q.push_back(mk(OP_LD, 3'd3, 1'b0, 1'b1, 1'b0, V_FETCH_RDY));
        q.push_back(mk(OP_LD, 3'd3, 1'b0, 1'b1, 1'b0, V_DECODE));
        q.push_back(mk(OP_LD, 3'd3, 1'b0, 1'b1, 1'b0, V_ADDR));
        for (int k = 0; k < 3; k++) q.push_back(mk(OP_LD, 3'd3, 1'b0, 1'b0, 1'b0, V_MEM_RD));
        q.push_back(mk(OP_LD, 3'd3, 1'b0, 1'b1, 1'b0, V_MEM_RD));
        q.push_back(mk(OP_LD, 3'd3, 1'b0, 1'b1, 1'b1, V_WB_MEM));
        q.push_back(mk(OP_ST, 3'd3, 1'b0, 1'b1, 1'b0, V_FETCH_RDY));
        q.push_back(mk(OP_ST, 3'd3, 1'b0, 1'b1, 1'b0, V_DECODE));
        q.push_back(mk(OP_ST, 3'd3, 1'b0, 1'b1, 1'b0, V_ADDR));
        q.push_back(mk(OP_ST, 3'd3, 1'b0, 1'b1, 1'b1, V_MEM_WR));
        foreach (q[i]) begin
            drive(q[i]);
            n_vec++;
            if ({observe(), bus.cycle_count, bus.instr_count} !== {q[i].want, exp_cyc, exp_instr}) begin
                n_err++;
                $display("FAIL mem step %0d: got %h/%0d/%0d want %h/%0d/%0d", i, observe(),
                         bus.cycle_count, bus.instr_count, q[i].want, exp_cyc, exp_instr);
            end
            tick();
            if (q[i].ret) exp_instr++;
        end
    endtask

    task automatic test_branch();
        step_t q[$];
        logic [2:0] f3_tab [4] = '{3'b000, 3'b000, 3'b001, 3'b001};
        logic       z_tab  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vec_t       br_tab [4] = '{V_BR_TAKEN, V_BR_NOT, V_BR_NOT, V_BR_TAKEN};
        for (int c = 0; c < 4; c++) begin
            q.push_back(mk(OP_BR, f3_tab[c], z_tab[c], 1'b1, 1'b0, V_FETCH_RDY));
            q.push_back(mk(OP_BR, f3_tab[c], z_tab[c], 1'b1, 1'b0, V_DECODE));
            q.push_back(mk(OP_BR, f3_tab[c], z_tab[c], 1'b1, 1'b1, br_tab[c]));
        end
        foreach (q[i]) begin
            drive(q[i]);
            n_vec++;
            if ({observe(), bus.cycle_count, bus.instr_count} !== {q[i].want, exp_cyc, exp_instr}) begin
                n_err++;
                $display("FAIL branch step %0d: got %h/%0d/%0d want %h/%0d/%0d", i, observe(),
                         bus.cycle_count, bus.instr_count, q[i].want, exp_cyc, exp_instr);
            end
            tick();
            if (q[i].ret) exp_instr++;
        end
    endtask

    task automatic test_reset_mid_write();
        step_t q[$];
        q.push_back(mk(OP_ST, 3'd3, 1'b0, 1'b1, 1'b0, V_FETCH_RDY));
        q.push_back(mk(OP_ST, 3'd3, 1'b0, 1'b1, 1'b0, V_DECODE));
        q.push_back(mk(OP_ST, 3'd3, 1'b0, 1'b1, 1'b0, V_ADDR));
        q.push_back(mk(OP_ST, 3'd3, 1'b0, 1'b0, 1'b0, V_MEM_WR));
        foreach (q[i]) begin
            drive(q[i]);
            n_vec++;
            if ({observe(), bus.cycle_count, bus.instr_count} !== {q[i].want, exp_cyc, exp_instr}) begin
                n_err++;
                $display("FAIL midwr step %0d: got %h/%0d/%0d want %h/%0d/%0d", i, observe(),
                         bus.cycle_count, bus.instr_count, q[i].want, exp_cyc, exp_instr);
            end
            if (i < 3) tick();
        end
        reset     = 1'b0;
        exp_cyc   = '0;
        exp_instr = '0;
        tick();
        n_vec++;
        if ({observe(), bus.cycle_count, bus.instr_count} !== {V_RESET, exp_cyc, exp_instr}) begin
            n_err++;
            $display("FAIL midwr reset: got %h/%0d/%0d want %h/%0d/%0d", observe(),
                     bus.cycle_count, bus.instr_count, V_RESET, exp_cyc, exp_instr);
        end
        reset = 1'b1;
        drive(mk(OP_ST, 3'd3, 1'b0, 1'b0, 1'b0, V_FETCH_STL));
        n_vec++;
        if ({observe(), bus.cycle_count, bus.instr_count} !== {V_FETCH_STL, exp_cyc, exp_instr}) begin
            n_err++;
            $display("FAIL midwr release: got %h/%0d/%0d want %h/%0d/%0d", observe(),
                     bus.cycle_count, bus.instr_count, V_FETCH_STL, exp_cyc, exp_instr);
        end
    endtask

    task automatic test_illegal_opcode();
        step_t q[$];
        q.push_back(mk(OP_BAD, 3'd0, 1'b0, 1'b1, 1'b0, V_FETCH_RDY));
        q.push_back(mk(OP_BAD, 3'd0, 1'b0, 1'b1, 1'b0, V_DECODE));
        q.push_back(mk(OP_BAD, 3'd0, 1'b0, 1'b1, 1'b0, V_TRAP));
        q.push_back(mk(OP_R,   3'd0, 1'b1, 1'b0, 1'b0, V_TRAP));
        q.push_back(mk(OP_LD,  3'd0, 1'b0, 1'b1, 1'b0, V_TRAP));
        foreach (q[i]) begin
            drive(q[i]);
            n_vec++;
            if ({observe(), bus.cycle_count, bus.instr_count} !== {q[i].want, exp_cyc, exp_instr}) begin
                n_err++;
                $display("FAIL illegal step %0d: got %h/%0d/%0d want %h/%0d/%0d", i, observe(),
                         bus.cycle_count, bus.instr_count, q[i].want, exp_cyc, exp_instr);
            end
            tick();
            if (q[i].ret) exp_instr++;
        end
        reset     = 1'b0;
        exp_cyc   = '0;
        exp_instr = '0;
        tick();
        n_vec++;
        if ({observe(), bus.cycle_count, bus.instr_count} !== {V_RESET, exp_cyc, exp_instr}) begin
            n_err++;
            $display("FAIL illegal reset: got %h/%0d/%0d want %h/%0d/%0d", observe(),
                     bus.cycle_count, bus.instr_count, V_RESET, exp_cyc, exp_instr);
        end
        reset = 1'b1;
        drive(mk(OP_R, 3'd0, 1'b0, 1'b0, 1'b0, V_FETCH_STL));
        n_vec++;
        if ({observe(), bus.cycle_count, bus.instr_count} !== {V_FETCH_STL, exp_cyc, exp_instr}) begin
            n_err++;
            $display("FAIL illegal release: got %h/%0d/%0d want %h/%0d/%0d", observe(),
                     bus.cycle_count, bus.instr_count, V_FETCH_STL, exp_cyc, exp_instr);
        end
    endtask

    task automatic test_fetch_timeout();
        step_t q[$];
        for (int k = 0; k < 14; k++) q.push_back(mk(OP_R, 3'd0, 1'b0, 1'b0, 1'b0, V_FETCH_STL));
        q.push_back(mk(OP_R, 3'd0, 1'b0, 1'b1, 1'b0, V_FETCH_RDY));
        q.push_back(mk(OP_R, 3'd0, 1'b0, 1'b1, 1'b0, V_DECODE));
        q.push_back(mk(OP_R, 3'd0, 1'b0, 1'b1, 1'b0, V_EXEC_R));
        q.push_back(mk(OP_R, 3'd0, 1'b0, 1'b1, 1'b1, V_WB_ALU));
        for (int k = 0; k < 15; k++) q.push_back(mk(OP_R, 3'd0, 1'b0, 1'b0, 1'b0, V_FETCH_STL));
        q.push_back(mk(OP_R, 3'd0, 1'b0, 1'b0, 1'b0, V_TRAP));
        q.push_back(mk(OP_R, 3'd0, 1'b0, 1'b1, 1'b0, V_TRAP));
        q.push_back(mk(OP_R, 3'd0, 1'b0, 1'b0, 1'b0, V_TRAP));
        foreach (q[i]) begin
            drive(q[i]);
            n_vec++;
            if ({observe(), bus.cycle_count, bus.instr_count} !== {q[i].want, exp_cyc, exp_instr}) begin
                n_err++;
                $display("FAIL timeout step %0d: got %h/%0d/%0d want %h/%0d/%0d", i, observe(),
                         bus.cycle_count, bus.instr_count, q[i].want, exp_cyc, exp_instr);
            end
            tick();
            if (q[i].ret) exp_instr++;
        end
    endtask

    initial begin
        test_reset();
        test_alu_back_to_back();
        test_mem_ops();
        test_branch();
        test_reset_mid_write();
        test_illegal_opcode();
        test_fetch_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached after %0d vectors", n_vec);
        $fatal(1);
    end

endmodule
